// File: rtl/mux_2to1_pkg.sv
// Shared select encoding for the 2-to-1 multiplexer.
// The two values name which data input the select bit steers to the output.
package mux_2to1_pkg;

    typedef enum logic {
        SEL_I0 = 1'b0,
        SEL_I1 = 1'b1
    } mux_sel_e;

endpackage

// File: rtl/mux_2to1_core.sv
// WIDTH-bit combinational 2-to-1 select. One select bit steers every data bit.
module mux_2to1_core
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             S,
    output logic [WIDTH-1:0] Y
);

    // A per-bit ternary merges the two inputs when S is unknown: bits where
    // I0 and I1 agree keep that value and the rest go X. Synthesis sees a plain mux.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign Y[gi] = (S == SEL_I1) ? I1[gi] : I0[gi];
        end
    endgenerate

endmodule

// File: rtl/mux_2to1.sv
// 2-to-1 multiplexer with a zero-latency output Y and a registered copy Y_q.
// vld_q reports whether Y_q holds data captured since the last reset.
module mux_2to1 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             S,
    input  logic             en,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic             vld_q
);

    logic [WIDTH-1:0] y_q_reg;
    logic             vld_q_reg;

    // The select core feeds both the combinational output and the register D input.
    mux_2to1_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .I0(I0),
        .I1(I1),
        .S (S),
        .Y (Y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_reg   <= RESET_VAL;
            vld_q_reg <= 1'b0;
        end else if (en) begin
            y_q_reg   <= Y;
            vld_q_reg <= 1'b1;
        end
    end

    assign Y_q   = y_q_reg;
    assign vld_q = vld_q_reg;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: WIDTH=1 truth table, then capture, hold,
// asynchronous reset and unknown-select behaviour on a WIDTH=8 instance.
module tb_mux_2to1;

    logic       clk;
    logic       clk_on;
    logic       rst_n;

    logic       i0_1, i1_1, s_1, en_1;
    logic       y_1, yq_1, vld_1;

    logic [7:0] i0_8, i1_8;
    logic       s_8, en_8;
    logic [7:0] y_8, yq_8;
    logic       vld_8;

    int errors = 0;
    int checks = 0;

    mux_2to1 #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .I0   (i0_1),
        .I1   (i1_1),
        .S    (s_1),
        .en   (en_1),
        .Y    (y_1),
        .Y_q  (yq_1),
        .vld_q(vld_1)
    );

    mux_2to1 #(.WIDTH(8)) u_dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .I0   (i0_8),
        .I1   (i1_8),
        .S    (s_8),
        .en   (en_8),
        .Y    (y_8),
        .Y_q  (yq_8),
        .vld_q(vld_8)
    );

    // Clock stays low until the truth-table phase is over.
    initial begin
        clk = 1'b0;
        wait (clk_on);
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Truth table vectors: {S, I0, I1, expected Y}
    logic [3:0] tt [8];

    initial begin
        tt[0] = 4'b0_0_0_0; tt[1] = 4'b0_1_0_1; tt[2] = 4'b0_0_1_0; tt[3] = 4'b0_1_1_1;
        tt[4] = 4'b1_0_0_0; tt[5] = 4'b1_1_0_0; tt[6] = 4'b1_0_1_1; tt[7] = 4'b1_1_1_1;

        clk_on = 1'b0;
        rst_n  = 1'b1;
        en_1 = 1'b0; i0_1 = 1'b0; i1_1 = 1'b0; s_1 = 1'b0;
        en_8 = 1'b0; i0_8 = 8'h00; i1_8 = 8'h00; s_8 = 1'b0;
        #1 rst_n = 1'b0;

        // WIDTH=1 exhaustive truth table, clock stopped and reset asserted.
        for (int v = 0; v < 8; v++) begin
            s_1  = tt[v][3];
            i0_1 = tt[v][2];
            i1_1 = tt[v][1];
            #10;
            check($sformatf("tt_s%0d_i0%0d_i1%0d", s_1, i0_1, i1_1), {7'b0, y_1}, {7'b0, tt[v][0]});
        end

        check("reset_yq", yq_8, 8'h00);
        check("reset_vld", {7'b0, vld_8}, 8'h00);

        clk_on = 1'b1;
        tick();
        tick();
        check("reset_held_yq", yq_8, 8'h00);
        check("reset_held_vld", {7'b0, vld_8}, 8'h00);

        // Release reset between edges; the first en=1 edge captures.
        rst_n = 1'b1;
        en_8 = 1'b1; i0_8 = 8'hA5; i1_8 = 8'h3C; s_8 = 1'b1;
        #1;
        check("comb_s1", y_8, 8'h3C);
        tick();
        check("cap_s1_yq", yq_8, 8'h3C);
        check("cap_s1_vld", {7'b0, vld_8}, 8'h01);

        s_8 = 1'b0;
        tick();
        check("cap_s0_yq", yq_8, 8'hA5);

        // Hold: en low, inputs change, Y tracks but Y_q does not.
        en_8 = 1'b0;
        i0_8 = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            s_8 = ~s_8;
            #1;
            check($sformatf("hold_comb_%0d", k), y_8, s_8 ? 8'h3C : 8'hFF);
            tick();
            check($sformatf("hold_yq_%0d", k), yq_8, 8'hA5);
            check($sformatf("hold_vld_%0d", k), {7'b0, vld_8}, 8'h01);
        end

        // Load 3C, then assert reset mid-cycle with en still high.
        en_8 = 1'b1; s_8 = 1'b1; i1_8 = 8'h3C;
        tick();
        check("pre_rst_yq", yq_8, 8'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_yq", yq_8, 8'h00);
        check("async_rst_vld", {7'b0, vld_8}, 8'h00);
        check("async_rst_comb", y_8, 8'h3C);
        tick();
        check("rst_low_edge_yq", yq_8, 8'h00);

        #2 rst_n = 1'b1;
        s_8 = 1'b0; i0_8 = 8'h5A;
        tick();
        check("post_rst_yq", yq_8, 8'h5A);
        check("post_rst_vld", {7'b0, vld_8}, 8'h01);

        // Unknown select: agreeing bits pass through, differing bits go X.
        s_8 = 1'bx; i0_8 = 8'hF0; i1_8 = 8'hF5;
        #10;
        check("selx_hi", {4'h0, y_8[7:4]}, 8'h0F);
        check("selx_agree_bits", {6'b0, y_8[3], y_8[1]}, 8'h00);
        if ($isunknown(s_8)) begin
            check("selx_unknown_b0", {7'b0, $isunknown(y_8[0])}, 8'h01);
            check("selx_unknown_b2", {7'b0, $isunknown(y_8[2])}, 8'h01);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
